// File: rtl/clock_period_monitor.sv
// clock_period_monitor: measures the rising-to-rising period (and optionally
// the high time) of a slow asynchronous clock-like input in system clock
// cycles, flags in-tolerance measurements, declares lock after LOCK_COUNT
// consecutive good periods and reports a stall when edges stop arriving.
// Optional feature macro: CLOCK_PERIOD_MONITOR_DUTY_EN (high-time
// measurement and 50% duty check folded into in_tol).
module clock_period_monitor #(
  parameter int unsigned      CNT_W           = 28,
  parameter logic [CNT_W-1:0] EXPECTED_PERIOD = CNT_W'(2),
  parameter logic [CNT_W-1:0] TOLERANCE       = CNT_W'(0),
  parameter int unsigned      LOCK_COUNT      = 4
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             in_tol,
  output logic             locked,
  output logic             stalled
);

  localparam int unsigned      MATCH_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   STALL_LIM = {EXPECTED_PERIOD, 1'b0} + {1'b0, TOLERANCE};
  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    WAIT_EDGE,
    MEASURE,
    LOCKED
  } state_e;

  state_e             state_q;
  logic               s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
  logic [MATCH_W-1:0] match_cnt_q;
  logic [MATCH_W-1:0] match_inc_c;
  logic [CNT_W-1:0]   period_q;
  logic               meas_valid_q, in_tol_q, locked_q, stalled_q;
  logic               rise_c, stall_c, meas_ok_c;
  logic [CNT_W-1:0]   per_diff_c;
  logic [CNT_W-1:0]   hi_val_c;

  assign rise_c      = s2_q & ~s3_q;
  assign stall_c     = {1'b0, per_cnt_q} > STALL_LIM;
  assign match_inc_c = match_cnt_q + MATCH_W'(1);

  // Period counter next value: restart on a rising edge, otherwise saturate
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (rise_c) begin
      per_cnt_d = CNT_W'(1);
    end else if (per_cnt_q != CNT_MAX) begin
      per_cnt_d = per_cnt_q + CNT_W'(1);
    end
  end

  // Absolute period deviation, computed without going negative
  always_comb begin
    per_diff_c = '0;
    if (per_cnt_q >= EXPECTED_PERIOD) begin
      per_diff_c = per_cnt_q - EXPECTED_PERIOD;
    end else begin
      per_diff_c = EXPECTED_PERIOD - per_cnt_q;
    end
  end

`ifdef CLOCK_PERIOD_MONITOR_DUTY_EN
  logic [CNT_W-1:0] hi_acc_q, hi_acc_d;
  logic [CNT_W-1:0] high_time_q;
  logic [CNT_W-1:0] half_c;
  logic [CNT_W-1:0] hi_diff_c;

  assign half_c    = per_cnt_q >> 1;
  assign hi_val_c  = hi_acc_q;
  assign high_time = high_time_q;

  // High-time accumulator next value: restart on rise, count high cycles
  always_comb begin
    hi_acc_d = hi_acc_q;
    if (rise_c) begin
      hi_acc_d = CNT_W'(1);
    end else if (s2_q && (hi_acc_q != CNT_MAX)) begin
      hi_acc_d = hi_acc_q + CNT_W'(1);
    end
  end

  // Duty deviation from half the period (rounded down) gates the tolerance
  always_comb begin
    hi_diff_c = '0;
    if (hi_acc_q >= half_c) begin
      hi_diff_c = hi_acc_q - half_c;
    end else begin
      hi_diff_c = half_c - hi_acc_q;
    end
    meas_ok_c = (per_diff_c <= TOLERANCE) && (hi_diff_c <= TOLERANCE);
  end

  // High-time accumulator and its captured measurement
  always_ff @(posedge clock_in) begin
    if (reset) begin
      hi_acc_q    <= '0;
      high_time_q <= '0;
    end else begin
      hi_acc_q <= hi_acc_d;
      if (rise_c && (state_q != WAIT_EDGE)) begin
        high_time_q <= hi_val_c;
      end
    end
  end
`else
  assign hi_val_c  = '0;
  assign high_time = '0;

  // Without the duty feature only the period decides tolerance
  always_comb begin
    meas_ok_c = (per_diff_c <= TOLERANCE);
  end
`endif

  // Synchronizer, period counter, measurement capture and lock/stall FSM
  always_ff @(posedge clock_in) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      per_cnt_q    <= '0;
      match_cnt_q  <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      in_tol_q     <= 1'b0;
      locked_q     <= 1'b0;
      stalled_q    <= 1'b0;
      state_q      <= WAIT_EDGE;
    end else begin
      s1_q         <= sig_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      per_cnt_q    <= per_cnt_d;
      meas_valid_q <= 1'b0;

      if (rise_c) begin
        stalled_q <= 1'b0;
      end

      if (rise_c && (state_q != WAIT_EDGE)) begin
        period_q     <= per_cnt_q;
        meas_valid_q <= 1'b1;
        in_tol_q     <= meas_ok_c;
      end

      case (state_q)
        WAIT_EDGE: begin
          if (rise_c) begin
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise_c) begin
            if (meas_ok_c) begin
              match_cnt_q <= match_inc_c;
              if (match_inc_c >= LOCK_TGT) begin
                locked_q <= 1'b1;
                state_q  <= LOCKED;
              end
            end else begin
              match_cnt_q <= '0;
            end
          end else if (stall_c) begin
            stalled_q   <= 1'b1;
            locked_q    <= 1'b0;
            match_cnt_q <= '0;
            state_q     <= WAIT_EDGE;
          end
        end
        LOCKED: begin
          if (rise_c) begin
            if (!meas_ok_c) begin
              match_cnt_q <= '0;
              locked_q    <= 1'b0;
              state_q     <= MEASURE;
            end
          end else if (stall_c) begin
            stalled_q   <= 1'b1;
            locked_q    <= 1'b0;
            match_cnt_q <= '0;
            state_q     <= WAIT_EDGE;
          end
        end
        default: begin
          state_q <= WAIT_EDGE;
        end
      endcase
    end
  end

  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign in_tol     = in_tol_q;
  assign locked     = locked_q;
  assign stalled    = stalled_q;

endmodule

// File: doc/clock_period_monitor.md
# clock_period_monitor

Measures the period and high time of a slow, divided clock-like signal in cycles of the fast system clock, and reports when it matches the expected divisor. It sits beside the clock divider and checks the divided clock (VGA pixel clock, ball/paddle tick) before downstream logic is enabled. `sig_in` is treated as asynchronous data, never used as a clock.

## Interface
- `EXPECTED_PERIOD`, 28'd2: nominal period of `sig_in` in `clock_in` cycles (≥2).
- `TOLERANCE`, 28'd0: allowed absolute deviation of the measured period.
- `LOCK_COUNT`, 4: consecutive in-tolerance periods required for lock (1..15).
- `CNT_W`, 28: counter and measurement width.

- `clock_in`, input, 1: system clock; all logic on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `sig_in`, input, 1: monitored signal (asynchronous).
- `period`, output, CNT_W: last measured rising-to-rising period.
- `high_time`, output, CNT_W: cycles high within the last period.
- `meas_valid`, output, 1: one-cycle pulse when `period`/`high_time` update.
- `in_tol`, output, 1: last measurement within `EXPECTED_PERIOD ± TOLERANCE`.
- `locked`, output, 1: lock achieved.
- `stalled`, output, 1: no rising edge within `2*EXPECTED_PERIOD + TOLERANCE` cycles.

## Operation
- Input path: 2-flop synchronizer (`s1`, `s2`), history flop `s3`; `rise = s2 & ~s3`.
- `per_cnt`: set to 1 on `rise`, else +1, saturating at all-ones.
- `hi_acc`: on `rise` set to 1, else +1 when `s2`=1, saturating.
- On `rise` in MEASURE/LOCKED:
  - `period <= per_cnt`, `high_time <= hi_acc`.
  - `meas_valid <= 1`.
  - `in_tol <= (|per_cnt − EXPECTED_PERIOD| ≤ TOLERANCE)`, computed unsigned by subtracting the smaller from the larger.
- FSM states: WAIT_EDGE (reset state), MEASURE, LOCKED.
- WAIT_EDGE -> MEASURE on the first `rise`. No measurement is produced, since the period is incomplete.
- MEASURE: on each `rise`, an in-tolerance measurement increments `match_cnt` and an out-of-tolerance one clears it. When `match_cnt` reaches `LOCK_COUNT` -> LOCKED, with `locked` = 1 in the same cycle as that `meas_valid`.
- LOCKED: an out-of-tolerance `rise` -> MEASURE, `match_cnt` = 0, `locked` = 0.
- Stall: in MEASURE/LOCKED, when `per_cnt` exceeds `2*EXPECTED_PERIOD + TOLERANCE`:
  - `stalled` = 1, `locked` = 0, `match_cnt` = 0 -> WAIT_EDGE.
  - `stalled` clears on the next `rise`.
- Stall threshold and `rise` in the same cycle: `rise` wins, and the measurement is taken normally.

## Timing
- Reset values: `period` = 0, `high_time` = 0, `meas_valid` = 0, `in_tol` = 0, `locked` = 0, `stalled` = 0. Synchronizer, counters and `match_cnt` are 0; FSM in WAIT_EDGE.
- Latency: if `sig_in` is first sampled high at edge k, `rise` is true in the cycle after edge k+1, and the registered outputs update at edge k+2.
- `meas_valid` is high for exactly one cycle per rising edge of `sig_in`. The outputs hold their values between pulses.
- Reset mid-operation: all state returns to the reset values on the next edge. The first measurement after reset needs two rising edges of `sig_in`.
- Throughput: for `EXPECTED_PERIOD` = 2, one measurement every 2 cycles.

## Configuration
- `CLOCK_PERIOD_MONITOR_DUTY_EN` defined:
  - `hi_acc` and `high_time` are implemented.
  - `in_tol` additionally requires `high_time` = `period`/2 ± `TOLERANCE`, with the `period` halving rounded down.
- Not defined:
  - `hi_acc` is not built and `high_time` is tied to 0.
  - `in_tol` depends on the period only.

## Test plan
- Defaults; `sig_in` 1-cycle high / 1-cycle low -> `period` = 2 and `high_time` = 1 on every `meas_valid`, `in_tol` = 1, `locked` = 1 on the 4th `meas_valid`.
- `EXPECTED_PERIOD` = 10, `TOLERANCE` = 1; periods 10, 9, 11, 10, then 13 -> `locked` rises on the 4th `meas_valid` and falls on the 5th, `in_tol` = 0 on the 5th.
- `EXPECTED_PERIOD` = 10, `TOLERANCE` = 0; `sig_in` held low after lock -> `stalled` = 1 and `locked` = 0 at `per_cnt` = 21. The next rise clears `stalled` with no `meas_valid`, and the following rise gives a valid measurement.
- `reset` pulsed for one cycle while LOCKED -> all outputs 0 on the next edge, and the first `meas_valid` follows the second subsequent rise.
- With DUTY_EN, `EXPECTED_PERIOD` = 8: 2-high/6-low waveform -> `period` = 8, `high_time` = 2, `in_tol` = 0, `locked` stays 0. Without the macro, the same waveform gives `in_tol` = 1, `high_time` = 0 and `locked` = 1.
